// File: rtl/avalon_burst_master.sv
// Avalon-MM burst master: takes one read/write command at a time and issues a single
// burst on the avl_* port, streaming write beats in and read beats out.
module avalon_burst_master #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BCNT_W     = 10,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic              avl_clk,
  input  logic              avl_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [BCNT_W-1:0] cmd_burstcount,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] avl_address,
  output logic [BCNT_W-1:0] avl_burstcount,
  output logic              avl_beginbursttransfer,
  output logic              avl_read,
  output logic              avl_write,
  output logic [DATA_W-1:0] avl_writedata,
  input  logic [DATA_W-1:0] avl_readdata,
  input  logic              avl_readdatavalid
);

  localparam int unsigned IdleW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StWrBurst, StRdReq, StRdData, StFinish} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [BCNT_W-1:0]   beat_q, beat_d;
  logic [IdleW-1:0]    idle_q, idle_d;
  logic                err_q, err_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_last_q, rd_last_d;
  logic                last_beat;

  assign last_beat      = (beat_q == bcnt_q - BCNT_W'(1));
  assign avl_address    = addr_q;
  assign avl_burstcount = bcnt_q;
  assign rd_valid       = rd_valid_q;
  assign rd_data        = rd_data_q;
  assign rd_last        = rd_last_q;

  always_comb begin
    state_d                = state_q;
    addr_d                 = addr_q;
    bcnt_d                 = bcnt_q;
    beat_d                 = beat_q;
    idle_d                 = idle_q;
    err_d                  = err_q;
    rd_valid_d             = 1'b0;
    rd_data_d              = rd_data_q;
    rd_last_d              = 1'b0;
    cmd_ready              = 1'b0;
    wr_ready               = 1'b0;
    avl_write              = 1'b0;
    avl_writedata          = '0;
    avl_read               = 1'b0;
    avl_beginbursttransfer = 1'b0;
    done                   = 1'b0;
    error                  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_address;
          bcnt_d  = (cmd_burstcount == '0) ? BCNT_W'(1) : cmd_burstcount;
          beat_d  = '0;
          idle_d  = '0;
          err_d   = 1'b0;
          state_d = cmd_write ? StWrBurst : StRdReq;
        end
      end
      StWrBurst: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          avl_write              = 1'b1;
          avl_writedata          = wr_data;
          avl_beginbursttransfer = (beat_q == '0);
          beat_d                 = beat_q + BCNT_W'(1);
          if (last_beat) state_d = StFinish;
        end
      end
      StRdReq: begin
        avl_read               = 1'b1;
        avl_beginbursttransfer = 1'b1;
        state_d                = StRdData;
      end
      StRdData: begin
        // A beat arriving in the timeout cycle still counts.
        if (avl_readdatavalid) begin
          rd_valid_d = 1'b1;
          rd_data_d  = avl_readdata;
          rd_last_d  = last_beat;
          beat_d     = beat_q + BCNT_W'(1);
          idle_d     = '0;
          if (last_beat) state_d = StFinish;
        end else if (idle_q == IdleW'(RD_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = StFinish;
        end else begin
          idle_d = idle_q + IdleW'(1);
        end
      end
      StFinish: begin
        done    = 1'b1;
        error   = err_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge avl_clk or negedge avl_rst_n) begin
    if (!avl_rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      bcnt_q     <= '0;
      beat_q     <= '0;
      idle_q     <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      bcnt_q     <= bcnt_d;
      beat_q     <= beat_d;
      idle_q     <= idle_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
    end
  end

endmodule

// File: tb/tb_avalon_burst_master.sv
// Directed bench for avalon_burst_master: write/read bursts, stalls, timeout, zero count, reset.
module tb_avalon_burst_master;

  logic       avl_clk = 1'b0;
  logic       avl_rst_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [9:0] cmd_address;
  logic [9:0] cmd_burstcount;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_last, done, error;
  logic [7:0] rd_data;
  logic [9:0] avl_address, avl_burstcount;
  logic       avl_beginbursttransfer, avl_read, avl_write;
  logic [7:0] avl_writedata, avl_readdata;
  logic       avl_readdatavalid;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 avl_clk = ~avl_clk;

  avalon_burst_master dut (
    .avl_clk                (avl_clk),
    .avl_rst_n              (avl_rst_n),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_write              (cmd_write),
    .cmd_address            (cmd_address),
    .cmd_burstcount         (cmd_burstcount),
    .wr_valid               (wr_valid),
    .wr_data                (wr_data),
    .wr_ready               (wr_ready),
    .rd_valid               (rd_valid),
    .rd_data                (rd_data),
    .rd_last                (rd_last),
    .done                   (done),
    .error                  (error),
    .avl_address            (avl_address),
    .avl_burstcount         (avl_burstcount),
    .avl_beginbursttransfer (avl_beginbursttransfer),
    .avl_read               (avl_read),
    .avl_write              (avl_write),
    .avl_writedata          (avl_writedata),
    .avl_readdata           (avl_readdata),
    .avl_readdatavalid      (avl_readdatavalid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge avl_clk);
    #2;
  endtask

  initial begin
    avl_rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0;
    cmd_burstcount = '0; wr_valid = 1'b0; wr_data = '0;
    avl_readdata = '0; avl_readdatavalid = 1'b0;
    #12;
    check("rst_write", avl_write, 0);
    check("rst_read", avl_read, 0);
    check("rst_done", done, 0);
    check("rst_rdvalid", rd_valid, 0);
    check("rst_addr", avl_address, 0);
    check("rst_bcnt", avl_burstcount, 0);
    avl_rst_n = 1'b1;
    step();

    // Write 4 beats at 0x010 with wr_valid held
    cmd_valid = 1; cmd_write = 1; cmd_address = 10'h010; cmd_burstcount = 10'd4;
    wr_valid = 1; wr_data = 8'hA1;
    #1;
    check("w1_cmd_ready", cmd_ready, 1);
    check("w1_idle_write", avl_write, 0);
    step();
    cmd_valid = 0;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'hA1 + 8'(i);
      #1;
      check("w1_write", avl_write, 1);
      check("w1_wdata", avl_writedata, 32'hA1 + i);
      check("w1_begin", avl_beginbursttransfer, (i == 0) ? 1 : 0);
      check("w1_addr", avl_address, 10'h010);
      check("w1_bcnt", avl_burstcount, 4);
      check("w1_nodone", done, 0);
      step();
    end
    wr_valid = 0;
    #1;
    check("w1_done", done, 1);
    check("w1_err", error, 0);
    check("w1_fin_write", avl_write, 0);
    check("w1_fin_ready", cmd_ready, 0);
    step();
    #1;
    check("w1_idle_done", done, 0);
    check("w1_idle_ready", cmd_ready, 1);

    // Write 3 beats at 0x020 with a 2-cycle wr_valid gap
    cmd_valid = 1; cmd_write = 1; cmd_address = 10'h020; cmd_burstcount = 10'd3;
    wr_valid = 1; wr_data = 8'hB1;
    step();
    cmd_valid = 0;
    #1;
    check("w2_b1_write", avl_write, 1);
    check("w2_b1_begin", avl_beginbursttransfer, 1);
    step();
    wr_valid = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("w2_gap_write", avl_write, 0);
      check("w2_gap_addr", avl_address, 10'h020);
      check("w2_gap_bcnt", avl_burstcount, 3);
      check("w2_gap_wready", wr_ready, 1);
      check("w2_gap_done", done, 0);
      step();
    end
    wr_valid = 1; wr_data = 8'hB2;
    #1;
    check("w2_b2_write", avl_write, 1);
    check("w2_b2_begin", avl_beginbursttransfer, 0);
    check("w2_b2_data", avl_writedata, 8'hB2);
    step();
    wr_data = 8'hB3;
    #1;
    check("w2_b3_write", avl_write, 1);
    check("w2_b3_done", done, 0);
    step();
    wr_valid = 0;
    #1;
    check("w2_done", done, 1);
    step();

    // Read 4 beats from 0x010; stray readdatavalid in IDLE must be ignored
    cmd_valid = 1; cmd_write = 0; cmd_address = 10'h010; cmd_burstcount = 10'd4;
    avl_readdatavalid = 1; avl_readdata = 8'hFF;
    step();
    cmd_valid = 0; avl_readdatavalid = 0;
    #1;
    check("r1_read", avl_read, 1);
    check("r1_begin", avl_beginbursttransfer, 1);
    check("r1_addr", avl_address, 10'h010);
    check("r1_bcnt", avl_burstcount, 4);
    check("r1_stray_ignored", rd_valid, 0);
    step();
    #1;
    check("r1_read_once", avl_read, 0);
    check("r1_begin_once", avl_beginbursttransfer, 0);
    for (int i = 0; i < 4; i++) begin
      avl_readdatavalid = 1; avl_readdata = 8'hA1 + 8'(i);
      step();
      check("r1_rvalid", rd_valid, 1);
      check("r1_rdata", rd_data, 32'hA1 + i);
      check("r1_rlast", rd_last, (i == 3) ? 1 : 0);
      check("r1_done", done, (i == 3) ? 1 : 0);
    end
    avl_readdatavalid = 0;
    step();
    #1;
    check("r1_fin_rvalid", rd_valid, 0);
    check("r1_back_idle", cmd_ready, 1);

    // Read 2 beats, slave returns only one -> timeout abort
    cmd_valid = 1; cmd_write = 0; cmd_address = 10'h040; cmd_burstcount = 10'd2;
    step();
    cmd_valid = 0;
    step();
    avl_readdatavalid = 1; avl_readdata = 8'h5A;
    step();
    avl_readdatavalid = 0;
    #1;
    check("to_rvalid", rd_valid, 1);
    check("to_rlast", rd_last, 0);
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    check("to_done", done, 1);
    check("to_error", error, 1);
    check("to_idle_span_ok", (n >= 250 && n <= 260) ? 1 : 0, 1);
    step();
    #1;
    check("to_idle_ready", cmd_ready, 1);
    check("to_err_cleared", error, 0);
    avl_readdatavalid = 1; avl_readdata = 8'h77;
    step();
    avl_readdatavalid = 0;
    #1;
    check("to_late_dropped", rd_valid, 0);

    // burstcount=0 write -> one beat; cmd_valid held during burst
    cmd_valid = 1; cmd_write = 1; cmd_address = 10'h030; cmd_burstcount = 10'd0;
    wr_valid = 1; wr_data = 8'hC3;
    step();
    #1;
    check("z_bcnt", avl_burstcount, 1);
    check("z_write", avl_write, 1);
    check("z_begin", avl_beginbursttransfer, 1);
    check("z_ready_busy", cmd_ready, 0);
    step();
    #1;
    check("z_done", done, 1);
    check("z_fin_write", avl_write, 0);
    check("z_fin_ready", cmd_ready, 0);
    cmd_valid = 0; wr_valid = 0;
    step();
    #1;
    check("z_idle_ready", cmd_ready, 1);
    check("z_idle_done", done, 0);

    // Async reset in the middle of a 4-beat write
    cmd_valid = 1; cmd_write = 1; cmd_address = 10'h050; cmd_burstcount = 10'd4;
    wr_valid = 1; wr_data = 8'hD1;
    step();
    cmd_valid = 0;
    step();
    #1;
    check("rs_mid_write", avl_write, 1);
    avl_rst_n = 0;
    #1;
    check("rs_write", avl_write, 0);
    check("rs_addr", avl_address, 0);
    check("rs_bcnt", avl_burstcount, 0);
    check("rs_wready", wr_ready, 0);
    check("rs_done", done, 0);
    step();
    check("rs_held_done", done, 0);
    avl_rst_n = 1; wr_valid = 0;
    step();
    #1;
    check("rs_after_done", done, 0);
    check("rs_after_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_write = 1; cmd_address = 10'h060; cmd_burstcount = 10'd1;
    wr_valid = 1; wr_data = 8'hE6;
    step();
    cmd_valid = 0;
    #1;
    check("rs_fresh_write", avl_write, 1);
    check("rs_fresh_addr", avl_address, 10'h060);
    step();
    wr_valid = 0;
    #1;
    check("rs_fresh_done", done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
